// File: rtl/add_arb_if.sv
// rtl/add_arb_if.sv - requester/response/adder bundle for add_arb; reqN_sub only with ADD_ARB_SUB_EN
interface add_arb_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
`ifdef ADD_ARB_SUB_EN
    logic        req0_sub;
    logic        req1_sub;
`endif
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic        rsp0_ready;
    logic        rsp1_ready;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

`ifdef ADD_ARB_SUB_EN
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_sum, rsp_cout,
        input  rsp0_ready, rsp1_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout
    );
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_sub, req1_sub,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_sum, rsp_cout,
        output rsp0_ready, rsp1_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout
    );
`else
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_sum, rsp_cout,
        input  rsp0_ready, rsp1_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout
    );
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_sum, rsp_cout,
        output rsp0_ready, rsp1_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout
    );
`endif
endinterface

// File: rtl/add_arb.sv
// rtl/add_arb.sv - two-requester round-robin front end for a shared external 32-bit adder
// Optional subtract support enabled by ADD_ARB_SUB_EN.
module add_arb (
    input  logic       clk,
    input  logic       rst_n,
    add_arb_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        prio;      // requester favoured when both are valid
    logic        owner;
    logic        gnt;
    logic        take;
    logic        sub_sel;
    logic        op_sub;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] res_sum;
    logic        res_cout;
    logic        rsp_done;

    always_comb begin
        gnt       = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
        take      = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
`ifdef ADD_ARB_SUB_EN
        sub_sel   = gnt ? bus.req1_sub : bus.req0_sub;
`else
        sub_sel   = 1'b0;
`endif
        rsp_done  = owner ? bus.rsp1_ready : bus.rsp0_ready;
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = take && !gnt;
        bus.req1_ready = take && gnt;
        bus.rsp0_valid = (state == RESP) && !owner;
        bus.rsp1_valid = (state == RESP) && owner;
        bus.rsp_sum    = res_sum;
        bus.rsp_cout   = res_cout;
        bus.add_a      = 32'd0;
        bus.add_b      = 32'd0;
        bus.add_cin    = 1'b0;
        if (state == EXEC) begin
            // subtraction as A + ~B + 1 so cout=1 means no borrow
            bus.add_a   = op_a;
            bus.add_b   = op_sub ? ~op_b : op_b;
            bus.add_cin = op_sub;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            op_sub   <= 1'b0;
            res_sum  <= 32'd0;
            res_cout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                owner  <= gnt;
                prio   <= ~gnt;
                op_a   <= gnt ? bus.req1_a : bus.req0_a;
                op_b   <= gnt ? bus.req1_b : bus.req0_b;
                op_sub <= sub_sel;
            end
            if (state == EXEC) begin
                res_sum  <= bus.add_sum;
                res_cout <= bus.add_cout;
            end
        end
    end
endmodule

// File: tb/tb_add_arb.sv
// tb/tb_add_arb.sv - directed self-checking bench for add_arb with a behavioural external adder
module tb_add_arb;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    add_arb_if bus ();

    add_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sub(input logic s0, input logic s1);
`ifdef ADD_ARB_SUB_EN
        bus.req0_sub = s0;
        bus.req1_sub = s1;
`else
        if (s0 || s1) $display("note: subtract not built");
`endif
    endtask

    // single-requester operation from IDLE with the response consumed immediately
    task automatic single_op(input logic sel, input logic [31:0] a, input logic [31:0] b,
                             input logic sub, input logic [31:0] exp_sum, input logic exp_cout);
        if (sel) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; set_sub(1'b0, sub);
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; set_sub(sub, 1'b0);
        end
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1 check("op_ready", sel ? bus.req1_ready : bus.req0_ready, 33'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        check("op_valid", sel ? bus.rsp1_valid : bus.rsp0_valid, 33'd1);
        check("op_sum",   bus.rsp_sum, exp_sum);
        check("op_cout",  bus.rsp_cout, exp_cout);
        step();
        check("op_idle", bus.rsp0_valid | bus.rsp1_valid, 33'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        set_sub(1'b0, 1'b0);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        vectors = 0;
        miscompares = 0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        set_sub(1'b0, 1'b0);

        #2;
        check("rst_rsp0_valid", bus.rsp0_valid, 33'd0);
        check("rst_rsp1_valid", bus.rsp1_valid, 33'd0);
        check("rst_rsp_sum",    bus.rsp_sum, 33'd0);
        check("rst_rsp_cout",   bus.rsp_cout, 33'd0);
        check("rst_add_a",      bus.add_a, 33'd0);
        check("rst_add_b",      bus.add_b, 33'd0);
        check("rst_add_cin",    bus.add_cin, 33'd0);
        #1 rst_n = 1'b1;
        step();

        // 5 + 3, latency and EXEC drive
        bus.req0_valid = 1'b1; bus.req0_a = 32'h5; bus.req0_b = 32'h3;
        #1;
        check("t1_req0_ready", bus.req0_ready, 33'd1);
        check("t1_req1_ready", bus.req1_ready, 33'd0);
        step();
        bus.req0_valid = 1'b0;
        #1;
        check("t1_exec_add_a",   bus.add_a, 33'h5);
        check("t1_exec_add_b",   bus.add_b, 33'h3);
        check("t1_exec_add_cin", bus.add_cin, 33'd0);
        check("t1_exec_no_rsp",  bus.rsp0_valid, 33'd0);
        step();
        check("t1_rsp0_valid", bus.rsp0_valid, 33'd1);
        check("t1_rsp1_valid", bus.rsp1_valid, 33'd0);
        check("t1_sum",        bus.rsp_sum, 33'h8);
        check("t1_cout",       bus.rsp_cout, 33'd0);
        check("t1_resp_add_a", bus.add_a, 33'd0);
        bus.rsp0_ready = 1'b1;
        step();
        check("t1_done", bus.rsp0_valid, 33'd0);
        bus.rsp0_ready = 1'b0;

        // FFFFFFFF + 1 on req1, stalled response with req0 waiting and rsp0_ready ignored
        bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'h1;
        #1 check("t2_req1_ready", bus.req1_ready, 33'd1);
        step();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'h7; bus.req0_b = 32'h9;
        bus.rsp0_ready = 1'b1;
        #1 check("t2_exec_req0_ready", bus.req0_ready, 33'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid",      bus.rsp1_valid, 33'd1);
            check("t2_hold_sum",        bus.rsp_sum, 33'h0);
            check("t2_hold_cout",       bus.rsp_cout, 33'd1);
            check("t2_hold_req0_ready", bus.req0_ready, 33'd0);
            step();
        end
        bus.rsp1_ready = 1'b1;
        #1 check("t2_last_valid", bus.rsp1_valid, 33'd1);
        step();
        bus.rsp1_ready = 1'b0;
        check("t2_released",   bus.rsp1_valid, 33'd0);
        check("t2_req0_grant", bus.req0_ready, 33'd1);
        step();
        bus.req0_valid = 1'b0;
        step();
        check("t2_req0_valid", bus.rsp0_valid, 33'd1);
        check("t2_req0_sum",   bus.rsp_sum, 33'h10);
        step();
        bus.rsp0_ready = 1'b0;

        // reset pulse during EXEC aborts the operation
        bus.req0_valid = 1'b1; bus.req0_a = 32'h1234; bus.req0_b = 32'h1;
        #1 check("t3_req0_ready", bus.req0_ready, 33'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        check("t3_exec_add_a", bus.add_a, 33'h1234);
        rst_n = 1'b0;
        #1;
        check("t3_rst_add_a",  bus.add_a, 33'd0);
        check("t3_rst_add_b",  bus.add_b, 33'd0);
        check("t3_rst_rsp0",   bus.rsp0_valid, 33'd0);
        check("t3_rst_sum",    bus.rsp_sum, 33'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_no_rsp", bus.rsp0_valid | bus.rsp1_valid, 33'd0);
        end
        bus.rsp0_ready = 1'b0;

        // dual request after reset: grants alternate 0,1,0,1, three cycles each
        bus.req0_valid = 1'b1; bus.req0_a = 32'h10; bus.req0_b = 32'h1;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h20; bus.req1_b = 32'h2;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            #1;
            check("t4_req0_ready", bus.req0_ready, {32'd0, (op % 2) == 0});
            check("t4_req1_ready", bus.req1_ready, {32'd0, (op % 2) == 1});
            step();
            check("t4_add_a", bus.add_a, ((op % 2) == 1) ? 33'h20 : 33'h10);
            step();
            check("t4_rsp_valid", ((op % 2) == 1) ? bus.rsp1_valid : bus.rsp0_valid, 33'd1);
            check("t4_sum", bus.rsp_sum, ((op % 2) == 1) ? 33'h22 : 33'h11);
            check("t4_resp_ready", bus.req0_ready | bus.req1_ready, 33'd0);
            step();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        step();

        single_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1);
        single_op(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
`ifdef ADD_ARB_SUB_EN
        single_op(1'b0, 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 1'b0);
        single_op(1'b1, 32'h5, 32'h3, 1'b1, 32'h2, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
